ai_sector_buffer: RTL

AI_SECTOR_BUFFER -- requirements
Module: ai_sector_buffer

---
 rtl/ai_pkg.sv | 19 +
 rtl/ai_sector_buffer_if.sv | 37 +++
 rtl/ai_sync_fifo.sv | 68 ++++++
 rtl/ai_sector_buffer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ai_pkg.sv
// ----------------------------------------------------------------------------
// ai_pkg
// Shared definitions for the sector buffer slice.
//   sector_state_t    framing state of the incoming card byte stream
//   TMR_CODE_DEFAULT  status byte the card uses to report a timeout
//   CRC_CODE_DEFAULT  status byte the card uses to report a CRC failure
// ----------------------------------------------------------------------------
package ai_pkg;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_LOCK    = 2'd2
  } sector_state_t;

  localparam logic [7:0] TMR_CODE_DEFAULT = 8'hFE;
  localparam logic [7:0] CRC_CODE_DEFAULT = 8'hFD;

endpackage

// File: rtl/ai_sector_buffer_if.sv
// ----------------------------------------------------------------------------
// ai_sector_buffer_if
// Byte bus between the card reader, the sector buffer and the downstream
// consumer.
//   card_data / card_rdy   byte stream from the card, one byte per strobe
//   b_data_out / b_data_rdy buffered payload byte and its valid flag
//   b_data_ack             consumer ready; byte is taken when rdy & ack
// slave  : the sector buffer side
// master : the card/consumer environment side
// ----------------------------------------------------------------------------
interface ai_sector_buffer_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] card_data;
  logic              card_rdy;
  logic [DATA_W-1:0] b_data_out;
  logic              b_data_rdy;
  logic              b_data_ack;

  modport slave (
    input  card_data,
    input  card_rdy,
    input  b_data_ack,
    output b_data_out,
    output b_data_rdy
  );

  modport master (
    output card_data,
    output card_rdy,
    output b_data_ack,
    input  b_data_out,
    input  b_data_rdy
  );

endinterface

// File: rtl/ai_sync_fifo.sv
// ----------------------------------------------------------------------------
// ai_sync_fifo
// Single-clock FIFO with occupancy output.
//   clk, rst    clock and asynchronous active-low reset
//   clear       synchronous flush; wins over push and pop in the same cycle
//   push        write push_data; accepted when not full, or when full and a
//               pop happens in the same cycle
//   pop         remove head entry; ignored when empty
//   pop_data    head entry, forced to zero while empty
//   level       number of stored entries (0..DEPTH)
//   empty/full  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module ai_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is fine as long as the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign level    = count;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ai_sector_buffer.sv
// ----------------------------------------------------------------------------
// ai_sector_buffer
// Frames the card byte stream into sectors (HDR_LEN status bytes followed by
// PAYLOAD_LEN data bytes), checks the status bytes, and buffers payload bytes
// in an output FIFO for the consumer. Any bad status byte or a FIFO overflow
// locks the block until init or reset; the FIFO keeps draining while locked.
//   clk, rst     clock and asynchronous active-low reset
//   init         synchronous restart of framing, FIFO, lock and overflow
//   bus          card input and buffered output (ai_sector_buffer_if.slave)
//   tmr_err      one-cycle pulse: timeout code or unknown nonzero status
//   crc_err      one-cycle pulse: CRC failure status
//   sector_done  one-cycle pulse after the last payload byte of a sector
//   locked       level: block is discarding card input
//   overflow     sticky: a payload byte was dropped on a full FIFO
//   fifo_level   current FIFO occupancy
// ----------------------------------------------------------------------------
module ai_sector_buffer
  import ai_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                HDR_LEN     = 2,
  parameter int                PAYLOAD_LEN = 512,
  parameter int                FIFO_DEPTH  = 16,
  parameter logic [DATA_W-1:0] TMR_CODE    = DATA_W'(TMR_CODE_DEFAULT),
  parameter logic [DATA_W-1:0] CRC_CODE    = DATA_W'(CRC_CODE_DEFAULT),
  localparam int               LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  ai_sector_buffer_if.slave    bus,
  output logic                 tmr_err,
  output logic                 crc_err,
  output logic                 sector_done,
  output logic                 locked,
  output logic                 overflow,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int             IDX_W     = $clog2(HDR_LEN + PAYLOAD_LEN);
  localparam logic [IDX_W-1:0] HDR_LAST  = IDX_W'(HDR_LEN - 1);
  localparam logic [IDX_W-1:0] SECT_LAST = IDX_W'(HDR_LEN + PAYLOAD_LEN - 1);

  sector_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tmr_q, tmr_d;
  logic             crc_q, crc_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             drop;

  // init flushes the FIFO, so a same-cycle pop must not count as a handshake.
  assign fifo_pop = bus.b_data_rdy && bus.b_data_ack && !init;
  assign drop     = fifo_full && !fifo_pop;

  ai_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (init),
    .push      (fifo_push),
    .push_data (bus.card_data),
    .pop       (fifo_pop),
    .pop_data  (bus.b_data_out),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.b_data_rdy = !fifo_empty;

  // State, byte index, sticky overflow and the registered status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HDR;
      idx_q   <= '0;
      tmr_q   <= 1'b0;
      crc_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      crc_q   <= crc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Framing decisions for the byte presented this cycle. Pulses are computed
  // here and appear on the outputs one cycle later through the registers.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_d     = 1'b0;
    crc_d     = 1'b0;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    fifo_push = 1'b0;

    if (init) begin
      state_d = ST_HDR;
      idx_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (bus.card_rdy) begin
            if (bus.card_data == '0) begin
              idx_d = idx_q + 1'b1;
              if (idx_q == HDR_LAST) state_d = ST_PAYLOAD;
            end else begin
              // Anything nonzero other than the CRC code is treated as a timeout.
              if (bus.card_data == TMR_CODE)      tmr_d = 1'b1;
              else if (bus.card_data == CRC_CODE) crc_d = 1'b1;
              else                                tmr_d = 1'b1;
              state_d = ST_LOCK;
            end
          end
        end

        ST_PAYLOAD: begin
          if (bus.card_rdy) begin
            if (drop) ovf_d = 1'b1;
            else      fifo_push = 1'b1;
            // The sector still completes even when its last byte was dropped.
            if (idx_q == SECT_LAST) begin
              done_d = 1'b1;
              idx_d  = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
            if (drop)                    state_d = ST_LOCK;
            else if (idx_q == SECT_LAST) state_d = ST_HDR;
          end
        end

        ST_LOCK: begin
          state_d = ST_LOCK;
        end

        default: begin
          state_d = ST_HDR;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign tmr_err     = tmr_q;
  assign crc_err     = crc_q;
  assign sector_done = done_q;
  assign overflow    = ovf_q;
  assign locked      = (state_q == ST_LOCK);

endmodule
